// File: rtl/ysyx_220066_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_220066_pkg
//  Description : Shared types and constants for the memory arbiter slice:
//                arbiter state encoding, the fixed fetch access code, the
//                read data returned on a timed-out transaction, and a helper
//                that sizes the bus wait counter.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_220066_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_IF = 2'd1,
        ST_GRANT_D  = 2'd2,
        ST_DONE     = 2'd3
    } arb_state_e;

    // Instruction fetches are always 32-bit unsigned accesses.
    localparam logic [2:0]  c_fetch_size = 3'b110;

    // Read data reported to the requester when the bus never answers.
    localparam logic [63:0] c_err_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Wait counter must hold TIMEOUT and is never narrower than 8 bits.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_220066_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_220066_rr_pick
//  Description : Combinational arbitration decision between the fetch and
//                data requesters.
//  Ports       : i_req_if  - fetch request
//                i_req_d   - data request
//                i_last_d  - 1 when the previous grant went to data
//                i_rr_en   - 1 = round-robin, 0 = data has fixed priority
//                o_grant   - one-hot grant, [0] = fetch, [1] = data
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_220066_rr_pick (
    input  logic       i_req_if,
    input  logic       i_req_d,
    input  logic       i_last_d,
    input  logic       i_rr_en,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req_if && i_req_d) begin
            // Contention: round-robin hands the bus to whoever did not
            // have it last; fixed priority always favours data.
            o_grant = (i_rr_en && i_last_d) ? 2'b01 : 2'b10;
        end else if (i_req_d) begin
            o_grant = 2'b10;
        end else if (i_req_if) begin
            o_grant = 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_220066_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_220066_mem_arb
//  Description : Two-port (instruction fetch / data) arbiter onto a single
//                request/acknowledge memory bus. One transaction at a time,
//                a bubble cycle after every completion, and a wait-cycle
//                timeout that aborts a hung transaction with all-ones data
//                and a sticky error flag.
//  Ports       : clk, rst (synchronous, active-low)
//                if_*   - fetch requester (req/addr in, ready/rdata out)
//                d_*    - data requester (req/wr/op/addr/wdata in,
//                         ready/rdata out)
//                bus_*  - memory bus (valid/wr/size/addr/wdata out,
//                         ack/rdata in)
//                err    - sticky timeout flag
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_220066_mem_arb #(
    parameter int TIMEOUT = 255,
    parameter bit RR_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [2:0]  d_op,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        bus_valid,
    output logic        bus_wr,
    output logic [2:0]  bus_size,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    output logic        err
);

    import ysyx_220066_pkg::*;

    localparam int            CW        = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);

    arb_state_e     r_state;
    arb_state_e     w_state_next;
    logic [1:0]     w_grant;
    logic           r_last_d;
    logic [CW-1:0]  r_wait_cnt;
    logic           w_in_grant;
    logic           w_ack;
    logic           w_timeout;

    logic           r_bus_valid;
    logic           r_bus_wr;
    logic [2:0]     r_bus_size;
    logic [63:0]    r_bus_addr;
    logic [63:0]    r_bus_wdata;
    logic           r_if_ready;
    logic [31:0]    r_if_rdata;
    logic           r_d_ready;
    logic [63:0]    r_d_rdata;
    logic           r_err;

    ysyx_220066_rr_pick u_pick (
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .i_last_d (r_last_d),
        .i_rr_en  (RR_EN),
        .o_grant  (w_grant)
    );

    // Acks are only meaningful while a transaction is on the bus.
    assign w_in_grant = (r_state == ST_GRANT_IF) || (r_state == ST_GRANT_D);
    assign w_ack      = w_in_grant && bus_ack;
    // Fires on the cycle whose missing ack would bring the count to TIMEOUT,
    // so bus_valid is high for exactly TIMEOUT unanswered cycles.
    assign w_timeout  = w_in_grant && !bus_ack && ((r_wait_cnt + 1'b1) == c_timeout);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant[1])      w_state_next = ST_GRANT_D;
                else if (w_grant[0]) w_state_next = ST_GRANT_IF;
            end
            ST_GRANT_IF,
            ST_GRANT_D: begin
                if (w_ack || w_timeout) w_state_next = ST_DONE;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_valid <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 3'd0;
            r_bus_addr  <= 64'd0;
            r_bus_wdata <= 64'd0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= 64'd0;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
            r_last_d    <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_bus_valid <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_last_d    <= w_grant[1];
                        if (w_grant[1]) begin
                            r_bus_wr    <= d_wr;
                            r_bus_size  <= d_op;
                            r_bus_addr  <= d_addr;
                            r_bus_wdata <= d_wdata;
                        end else begin
                            r_bus_wr    <= 1'b0;
                            r_bus_size  <= c_fetch_size;
                            r_bus_addr  <= if_addr;
                            r_bus_wdata <= 64'd0;
                        end
                    end
                end
                ST_GRANT_IF,
                ST_GRANT_D: begin
                    if (w_ack || w_timeout) begin
                        r_bus_valid <= 1'b0;
                        if (w_timeout) r_err <= 1'b1;
                        if (r_state == ST_GRANT_IF) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= w_ack ? bus_rdata[31:0] : c_err_rdata[31:0];
                        end else begin
                            r_d_ready <= 1'b1;
                            // Stores leave the last load result in place.
                            if (w_timeout)     r_d_rdata <= c_err_rdata;
                            else if (!r_bus_wr) r_d_rdata <= bus_rdata;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_valid = r_bus_valid;
    assign bus_wr    = r_bus_wr;
    assign bus_size  = r_bus_size;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;

endmodule
`default_nettype wire
